cpu_trace_buffer: RTL and testbench
===================================

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter FETCH_STATE, default 7'd0, meaning the controller state code of instruction fetch.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port estado, input, 7, the current controller state from the CPU.
REQ-006 SHALL have port pc, input, 32, the current PC register value.
REQ-007 SHALL have port wb_data, input, 32, the current register-file write-back mux value.
REQ-008 SHALL have port overflow, input, 1, the ALU overflow flag.
REQ-009 SHALL have port arm, input, 1, a one-cycle pulse that starts capture.
REQ-010 SHALL have ports trig_en (input, 1) and trig_pc (input, 32), which enable the trigger and give the trigger PC.
REQ-011 SHALL have port post_count, input, 4, the number of entries captured after the trigger.
REQ-012 SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_data (output, 72), the read handshake; rd_data is {seq[6:0], overflow, pc, wb_data}.
REQ-013 SHALL have ports mode (output, 2), fill (output, 7) and dropped (output, 8), giving state, occupancy and the saturating lost-entry count.

Function
REQ-014 SHALL define the fetch event as estado==FETCH_STATE in a cycle where estado_q (the previous cycle's estado) != FETCH_STATE.
REQ-015 SHALL implement the states IDLE(0), CAPTURE(1), POST(2) and HALT(3), and mode SHALL equal the state code.
REQ-016 SHALL, in IDLE, capture nothing, and SHALL go to CAPTURE on arm.
REQ-017 SHALL, in CAPTURE, push one entry per fetch event.
REQ-018 SHALL, in CAPTURE, enter POST on a fetch event with trig_en=1 and pc==trig_pc, and the triggering entry SHALL itself be pushed.
REQ-019 SHALL, in POST, push fetch events and decrement the post counter (loaded with post_count on entry); the transition to HALT SHALL happen on the cycle the counter reaches 0 via a push, and post_count=0 SHALL go to HALT the cycle after the trigger.
REQ-020 SHALL, in HALT, capture nothing, and arm SHALL return to CAPTURE without clearing the FIFO, dropped or seq.
REQ-021 SHALL ignore arm in CAPTURE and POST.
REQ-022 SHALL build each entry from the same-cycle pc, wb_data and overflow plus seq, a 7-bit counter that increments on every fetch event in CAPTURE/POST whether pushed or dropped, wrapping 127->0.
REQ-023 SHALL, when a push occurs with fill==DEPTH and no pop in that cycle, drop the entry and increment dropped, saturating at 255.
REQ-024 SHALL perform both the push and the pop when they happen in the same cycle, full or empty, and fill SHALL be unchanged.
REQ-025 SHALL drive rd_valid = (fill!=0), with rd_data equal to the head entry combinationally.
REQ-026 SHALL pop when rd_valid && rd_ready, and SHALL ignore rd_ready while empty.
REQ-027 SHALL make a pushed entry visible on rd_valid in the cycle after the fetch event (latency 1).
REQ-028 SHALL wrap the read and write pointers modulo DEPTH, and fill SHALL range 0..DEPTH.

Reset
REQ-029 SHALL, while reset==0 at a clock edge, set state IDLE, pointers 0, fill 0, seq 0, dropped 0, post counter 0 and estado_q=FETCH_STATE, which suppresses a spurious event immediately after reset.
REQ-030 SHALL drive rd_valid=0, mode=0 and rd_data=0 as output values after reset.
REQ-031 SHALL discard all entries on reset asserted mid-capture, including in the same cycle as a push or pop.

Structure
REQ-032 SHALL place the state encoding, the entry width 72 and the entry field offsets in a shared package trace_pkg.
REQ-033 SHALL implement storage as one sub-module, trace_fifo (DEPTH x 72, push/pop/full/empty/count), with the FSM and seq/dropped logic in the top.

Verification
REQ-034 SHALL cover: arm, then 3 fetch events with pc=0x0,0x4,0x8 -> 3 entries, seq 0,1,2, first rd_valid 1 cycle after the first event.
REQ-035 SHALL cover: trig_en=1, trig_pc=0x10, post_count=2, fetches 0x0..0x20 step 4 -> entries 0x0..0x18, mode=3 after 0x18, no further pushes.
REQ-036 SHALL cover: DEPTH=16, rd_ready=0, 20 fetch events -> fill=16, dropped=4, seq in the head entry = 0, and 300 events -> dropped=255.
REQ-037 SHALL cover: full FIFO with a push and a pop in the same cycle -> fill stays 16, dropped unchanged, the new entry at the tail.
REQ-038 SHALL cover: reset=0 for one cycle mid-POST with 5 entries -> next cycle fill=0, rd_valid=0, mode=0, and estado held at FETCH_STATE through release produces no entry.
REQ-039 SHALL cover: estado held at FETCH_STATE for 4 cycles -> exactly one entry, and overflow=1 at the event -> bit 64 set.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and entry layout for the CPU trace buffer.
// One entry is {seq[6:0], overflow, pc[31:0], wb_data[31:0]}.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam int ENTRY_W = 72;
  localparam int WB_LSB  = 0;
  localparam int PC_LSB  = 32;
  localparam int OVF_BIT = 64;
  localparam int SEQ_LSB = 65;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [6:0]  seq,
    input logic        ovf,
    input logic [31:0] pc,
    input logic [31:0] wb
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[SEQ_LSB +: 7]  = seq;
    e[OVF_BIT]       = ovf;
    e[PC_LSB +: 32]  = pc;
    e[WB_LSB +: 32]  = wb;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Entry storage for the trace buffer: DEPTH x 72 circular FIFO.
// A push into a full FIFO is accepted only when a pop frees a slot.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [6:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == 7'd0);
  assign full    = (count == 7'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {6'd0, do_push} - {6'd0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures one entry per instruction fetch into a FIFO, with a PC
// trigger followed by a programmable number of post-trigger entries.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter logic [6:0] FETCH_STATE = 7'd0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         estado,
  input  logic [31:0]        pc,
  input  logic [31:0]        wb_data,
  input  logic               overflow,
  input  logic               arm,
  input  logic               trig_en,
  input  logic [31:0]        trig_pc,
  input  logic [3:0]         post_count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         mode,
  output logic [6:0]         fill,
  output logic [7:0]         dropped
);

  state_t     state;
  state_t     state_d;
  logic [6:0] estado_q;
  logic [6:0] seq;
  logic [3:0] pcnt;
  logic [3:0] pcnt_d;
  logic [7:0] drop_q;
  logic       fetch;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       lost;

  assign fetch = (estado == FETCH_STATE) && (estado_q != FETCH_STATE);
  assign push  = fetch && (state == CAPTURE || state == POST);
  assign pop   = rd_valid && rd_ready;
  assign lost  = push && full && !pop;

  assign rd_valid = !empty;
  assign mode     = state;
  assign dropped  = drop_q;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pack_entry(seq, overflow, pc, wb_data)),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  // estado_q resets to the fetch code so a held fetch state is not an event
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      estado_q <= FETCH_STATE;
      seq      <= '0;
      pcnt     <= '0;
      drop_q   <= '0;
    end else begin
      state    <= state_d;
      estado_q <= estado;
      pcnt     <= pcnt_d;
      if (push) seq <= seq + 7'd1;
      if (lost && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    unique case (state)
      IDLE: if (arm) state_d = CAPTURE;
      CAPTURE: begin
        if (push && trig_en && pc == trig_pc) begin
          state_d = POST;
          pcnt_d  = post_count;
        end
      end
      POST: begin
        if (pcnt == 4'd0) begin
          state_d = HALT;
        end else if (push) begin
          pcnt_d = pcnt - 4'd1;
          if (pcnt == 4'd1) state_d = HALT;
        end
      end
      HALT: if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed and random checks of cpu_trace_buffer against a queue model.
// The model is updated at every rising edge and compared 1 ns later.
module tb_cpu_trace_buffer;

  localparam int         DEPTH = 16;
  localparam logic [6:0] F     = 7'd0;
  localparam logic [6:0] NF    = 7'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  estado = NF;
  logic [31:0] pc = '0;
  logic [31:0] wb_data = '0;
  logic        overflow = 1'b0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [3:0]  post_count = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [71:0] rd_data;
  logic [1:0]  mode;
  logic [6:0]  fill;
  logic [7:0]  dropped;

  int checks = 0;
  int errors = 0;

  logic [71:0] q[$];
  int          st    = 0;
  int          mseq  = 0;
  int          mdrop = 0;
  int          mpcnt = 0;
  logic [6:0]  meq   = F;

  cpu_trace_buffer #(.DEPTH(DEPTH), .FETCH_STATE(F)) dut (
    .clock      (clock),
    .reset      (reset),
    .estado     (estado),
    .pc         (pc),
    .wb_data    (wb_data),
    .overflow   (overflow),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .post_count (post_count),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .mode       (mode),
    .fill       (fill),
    .dropped    (dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ev;
    bit cap;
    logic [71:0] e;
    if (!reset) begin
      q.delete();
      st = 0; mseq = 0; mdrop = 0; mpcnt = 0; meq = F;
      return;
    end
    ev  = (estado == F) && (meq != F);
    cap = ev && (st == 1 || st == 2);
    e   = {7'(mseq), overflow, pc, wb_data};
    if (q.size() != 0 && rd_ready) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (mdrop < 255) mdrop++;
      mseq = (mseq + 1) % 128;
    end
    case (st)
      0: if (arm) st = 1;
      1: if (cap && trig_en && pc == trig_pc) begin
           st = 2; mpcnt = int'(post_count);
         end
      2: if (mpcnt == 0) st = 3;
         else if (cap) begin
           mpcnt--;
           if (mpcnt == 0) st = 3;
         end
      default: if (arm) st = 1;
    endcase
    meq = estado;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("mode", 72'(mode), 72'(st));
    chk("fill", 72'(fill), 72'(q.size()));
    chk("dropped", 72'(dropped), 72'(mdrop));
    chk("rd_valid", 72'(rd_valid), 72'(q.size() != 0));
    chk("rd_data", rd_data, (q.size() != 0) ? q[0] : 72'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    estado  = F;
    pc      = a;
    wb_data = $urandom;
    step();
    estado = NF;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    logic [6:0] s;

    step();
    step();
    chk("rst_rd_data", rd_data, 72'd0);
    chk("rst_mode", 72'(mode), 72'd0);
    reset = 1'b1;
    step();

    // basic capture: three fetches, latency 1, seq 0..2
    do_arm();
    estado = F; pc = 32'h0; wb_data = $urandom;
    step();
    chk("lat1_valid", 72'(rd_valid), 72'd1);
    estado = NF;
    step();
    fetch(32'h4);
    fetch(32'h8);
    chk("three_fill", 72'(fill), 72'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = rd_data[71:65];
      chk("seq_order", 72'(s), 72'(i));
      step();
    end
    rd_ready = 1'b0;

    // trigger at 0x10 with two post entries
    do_reset();
    do_arm();
    trig_en = 1'b1; trig_pc = 32'h10; post_count = 4'd2;
    for (int a = 0; a <= 'h18; a += 4) fetch(32'(a));
    chk("trig_halt", 72'(mode), 72'd3);
    fetch(32'h1c);
    fetch(32'h20);
    chk("trig_fill", 72'(fill), 72'd7);
    trig_en = 1'b0;

    // overflow of the FIFO and saturation of dropped
    do_reset();
    do_arm();
    for (int i = 0; i < 20; i++) fetch(32'(i * 4));
    chk("full_fill", 72'(fill), 72'd16);
    chk("full_drop", 72'(dropped), 72'd4);
    s = rd_data[71:65];
    chk("full_head_seq", 72'(s), 72'd0);
    for (int i = 20; i < 300; i++) fetch(32'(i * 4));
    chk("drop_sat", 72'(dropped), 72'd255);

    // push and pop together while full
    estado = F; pc = 32'habc; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0; estado = NF;
    step();
    chk("pp_fill", 72'(fill), 72'd16);
    chk("pp_drop", 72'(dropped), 72'd255);
    rd_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("pp_tail", 72'(rd_data[63:32]), 72'h abc);
    step();
    rd_ready = 1'b0;

    // reset mid-POST, in the same cycle as a push
    do_reset();
    do_arm();
    trig_en = 1'b1; trig_pc = 32'h8; post_count = 4'd5;
    for (int a = 0; a <= 'h10; a += 4) fetch(32'(a));
    chk("post_mode", 72'(mode), 72'd2);
    estado = F; pc = 32'h14; reset = 1'b0;
    step();
    chk("mid_rst_fill", 72'(fill), 72'd0);
    chk("mid_rst_valid", 72'(rd_valid), 72'd0);
    chk("mid_rst_mode", 72'(mode), 72'd0);
    reset = 1'b1;
    do_arm();
    for (int i = 0; i < 3; i++) step();
    chk("held_no_entry", 72'(fill), 72'd0);
    trig_en = 1'b0;

    // held fetch state gives one entry; overflow lands in bit 64
    estado = NF;
    step();
    estado = F; pc = 32'h40; overflow = 1'b1;
    step();
    overflow = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("held_one", 72'(fill), 72'd1);
    chk("ovf_bit", 72'(rd_data[64]), 72'd1);
    estado = NF;
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom % 64) != 0;
      estado     = ($urandom % 2) ? F : 7'($urandom_range(1, 3));
      pc         = 32'($urandom_range(0, 7) * 4);
      trig_pc    = 32'($urandom_range(0, 7) * 4);
      trig_en    = 1'($urandom);
      arm        = ($urandom % 8) == 0;
      post_count = 4'($urandom);
      rd_ready   = ($urandom % 3) == 0;
      wb_data    = $urandom;
      overflow   = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
